// File: rtl/sha_digest_axis_tx.sv
// sha_digest_axis_tx
//
// AXI-Stream master on the output side of the SHA3 core. When the Keccak
// permutation reports a finished state (Din_valid), the low 512 bits of the
// state are captured together with the digest mode and a stream ID. The
// truncated digest (224/256/384/512 bits) is then sent as DATA_WIDTH-bit
// beats. Lane 0 goes first, and each lane is little-endian. TLAST marks the
// final beat.
//
// Ports
//   ACLK       in   clock, rising edge
//   ARESET     in   synchronous active-high reset
//   Din        in   1600-bit Keccak state (lane i at Din[64*i +: 64])
//   Din_valid  in   one-cycle pulse, Din holds a finished state
//   Mode       in   digest select: 0=224, 1=256, 2=384, 3=512
//   ID         in   stream ID captured with the digest
//   Busy       out  a digest is held or being sent
//   Overrun    out  sticky: a Din_valid pulse was dropped
//   TVALID     out  AXI-S valid
//   TREADY     in   AXI-S ready
//   TDATA      out  beat data
//   TKEEP      out  byte enables (partial only on a short final beat)
//   TLAST      out  final beat of the digest
//   TUSER      out  captured Mode
//   TID        out  captured ID
//
// State | meaning
// ------+-----------------------------------------------------------
// IDLE  | nothing held; the next Din_valid captures a digest
// SEND  | digest held; beats are offered until the TLAST beat transfers
module sha_digest_axis_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [1599:0]           Din,
    input  logic                    Din_valid,
    input  logic [1:0]              Mode,
    input  logic [ID_WIDTH-1:0]     ID,
    output logic                    Busy,
    output logic                    Overrun,
    output logic                    TVALID,
    input  logic                    TREADY,
    output logic [DATA_WIDTH-1:0]   TDATA,
    output logic [DATA_WIDTH/8-1:0] TKEEP,
    output logic                    TLAST,
    output logic [1:0]              TUSER,
    output logic [ID_WIDTH-1:0]     TID
);

    localparam int KEEP_W    = DATA_WIDTH / 8;
    localparam int NUM_WORDS = 512 / DATA_WIDTH;
    localparam int IDX_W     = $clog2(NUM_WORDS);

    // Index of the final beat for each mode; round up so a 224-bit digest on
    // a 64-bit bus still gets its trailing half-beat.
    localparam logic [4:0] LAST_224 = 5'(((224 + DATA_WIDTH - 1) / DATA_WIDTH) - 1);
    localparam logic [4:0] LAST_256 = 5'((256 / DATA_WIDTH) - 1);
    localparam logic [4:0] LAST_384 = 5'((384 / DATA_WIDTH) - 1);
    localparam logic [4:0] LAST_512 = 5'((512 / DATA_WIDTH) - 1);

    // The other digest sizes divide every legal width, so only the 224-bit
    // digest can end on a partial beat.
    localparam int REM_224 = 224 % DATA_WIDTH;
    localparam logic [KEEP_W-1:0] KEEP_ALL = {KEEP_W{1'b1}};
    localparam logic [KEEP_W-1:0] KEEP_224_LAST =
        (REM_224 == 0) ? KEEP_ALL : KEEP_W'((64'd1 << (REM_224 / 8)) - 64'd1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [511:0]          buf_q;
    logic [1:0]            mode_q;
    logic [ID_WIDTH-1:0]   id_q;
    logic                  ovr_q, ovr_d;
    logic                  capture;

    logic [4:0]            last_idx;
    logic                  is_last;
    logic                  xfer;
    logic [DATA_WIDTH-1:0] words [NUM_WORDS];

    // Bits above 511 are never part of any supported digest.
    logic unused_din_hi;
    assign unused_din_hi = ^Din[1599:512];

    for (genvar w = 0; w < NUM_WORDS; w++) begin : g_words
        assign words[w] = buf_q[w*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        last_idx = LAST_224;
        case (mode_q)
            2'd0:    last_idx = LAST_224;
            2'd1:    last_idx = LAST_256;
            2'd2:    last_idx = LAST_384;
            default: last_idx = LAST_512;
        endcase
    end

    assign is_last = (cnt_q == last_idx);
    assign xfer    = TVALID && TREADY;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ovr_d   = ovr_q;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (Din_valid) begin
                    capture = 1'b1;
                    cnt_d   = 5'd0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (xfer) begin
                    if (is_last) begin
                        cnt_d = 5'd0;
                        // A state arriving on the closing beat is taken
                        // directly, so the stream runs back-to-back.
                        if (Din_valid) begin
                            capture = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
                if (Din_valid && !(xfer && is_last)) begin
                    ovr_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q <= IDLE;
            cnt_q   <= 5'd0;
            buf_q   <= '0;
            mode_q  <= 2'd0;
            id_q    <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
            if (capture) begin
                buf_q  <= Din[511:0];
                mode_q <= Mode;
                id_q   <= ID;
            end
        end
    end

    assign TVALID  = (state_q == SEND);
    assign Busy    = (state_q == SEND);
    assign Overrun = ovr_q;
    assign TDATA   = words[cnt_q[IDX_W-1:0]];
    assign TLAST   = TVALID && is_last;
    assign TUSER   = mode_q;
    assign TID     = id_q;

    always_comb begin
        TKEEP = '0;
        if (TVALID) begin
            TKEEP = (is_last && (mode_q == 2'd0)) ? KEEP_224_LAST : KEEP_ALL;
        end
    end

endmodule
